// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer controller and the display/LED logic.
package countdown_pkg;

  // Controller state encoding; the display logic decodes these values directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // 1 s decrement tick at a 100 MHz system clock.
  localparam int DEFAULT_TICK_DIV = 100_000_000;
  localparam int DEFAULT_CNT_W    = 27;

  // States in which the prescaler free-runs.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/one_pulse.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
// A held level yields a single one-cycle pulse, coincident with the rising edge.
module one_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);

  logic level_d;

  // Registered copy of the level for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level_in;
    end
  end

  assign pulse_out = level_in & ~level_d;

endmodule

// File: rtl/countdown_ctrl.sv
// Run/pause/clear controller for the countdown timer. Drives the decrease input of
// the least-significant down-counter digit from a divided clock tick and stops with
// a blinking done indication once the downstream digits reach zero.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | stopped, prescaler cleared; waits for start
//  ST_RUN   | prescaler counting; each tick requests one decrement
//  ST_PAUSE | stopped, prescaler frozen so the partial second is kept
//  ST_DONE  | count reached zero; prescaler counting, done_led blinks
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_start,
  input  logic pb_clear,
  input  logic count_zero,
  output logic decrease,
  output logic load,
  output logic running,
  output logic done_led
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] presc;
  logic             tick;
  logic             start_ev;
  logic             clr_ev;
  logic             dec_nxt;
  logic             load_nxt;

  one_pulse u_start_pulse (
    .clk       (clk),
    .rst       (rst),
    .level_in  (pb_start),
    .pulse_out (start_ev)
  );

  one_pulse u_clear_pulse (
    .clk       (clk),
    .rst       (rst),
    .level_in  (pb_clear),
    .pulse_out (clr_ev)
  );

  assign tick = (presc == TICK_LAST);

  // Next-state and pulse decisions; priority clr_ev > count_zero > start_ev > tick.
  always_comb begin
    state_nxt = state;
    dec_nxt   = 1'b0;
    load_nxt  = 1'b0;
    if (clr_ev) begin
      state_nxt = ST_IDLE;
      load_nxt  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ev) begin
            state_nxt = count_zero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (count_zero) begin
            state_nxt = ST_DONE;
          end else if (start_ev) begin
            state_nxt = ST_PAUSE;
          end else if (tick) begin
            dec_nxt = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_ev) begin
            state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, prescaler and registered outputs. The prescaler only advances while the
  // FSM stays within RUN/DONE, so the value frozen on pause entry is the one resumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      presc    <= '0;
      decrease <= 1'b0;
      load     <= 1'b0;
      running  <= 1'b0;
      done_led <= 1'b0;
    end else begin
      state    <= state_nxt;
      running  <= (state_nxt == ST_RUN);
      decrease <= dec_nxt;
      load     <= load_nxt;

      if (state_nxt == ST_IDLE) begin
        presc <= '0;
      end else if (is_counting(state) && is_counting(state_nxt)) begin
        presc <= tick ? '0 : presc + CNT_ONE;
      end

      if (state_nxt != ST_DONE) begin
        done_led <= 1'b0;
      end else if ((state == ST_DONE) && tick) begin
        done_led <= ~done_led;
      end
    end
  end

endmodule
